// File: rtl/my_clipper_decode.sv
// rtl/my_clipper_decode.sv - Avalon-ST video decoder: latches control-packet geometry, forwards video data
module my_clipper_decode #(
  parameter int DATA_WIDTH  = 8,
  parameter int DATA_BITS   = 8,
  parameter int DATA_PLANES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din_data,
  input  logic                  din_valid,
  input  logic                  din_startofpacket,
  input  logic                  din_endofpacket,
  output logic                  din_ready,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_valid,
  output logic                  dout_startofpacket,
  output logic                  dout_endofpacket,
  input  logic                  dout_ready,
  output logic [15:0]           video_width,
  output logic [15:0]           video_height,
  output logic [3:0]            video_interlaced,
  output logic                  ctrl_valid,
  output logic                  ctrl_error
);

  localparam logic [3:0] NW = (DATA_PLANES == 1) ? 4'd9 :
                              (DATA_PLANES == 2) ? 4'd5 : 4'd3;

  typedef enum logic [2:0] {IDLE, CTRL, HDR0, DATA, DROP} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n, cnt_inc;
  logic [35:0] shadow, shadow_n;
  logic        ctrl_valid_n, ctrl_error_n, commit;
  logic        pass, beat;
  logic [3:0]  ptype;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= 4'd0;
      shadow           <= 36'd0;
      video_width      <= 16'd0;
      video_height     <= 16'd0;
      video_interlaced <= 4'd0;
      ctrl_valid       <= 1'b0;
      ctrl_error       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      shadow     <= shadow_n;
      ctrl_valid <= ctrl_valid_n;
      ctrl_error <= ctrl_error_n;
      // shadow_n already holds the eop beat's nibbles, so outputs update on the eop edge
      if (commit) begin
        video_width      <= shadow_n[35:20];
        video_height     <= shadow_n[19:4];
        video_interlaced <= shadow_n[3:0];
      end
    end
  end

  assign ptype   = din_data[3:0];
  assign cnt_inc = (cnt == 4'hF) ? cnt : cnt + 4'd1;

  always_comb begin
    state_n            = state;
    cnt_n              = cnt;
    shadow_n           = shadow;
    ctrl_valid_n       = 1'b0;
    ctrl_error_n       = 1'b0;
    commit             = 1'b0;
    din_ready          = 1'b0;
    dout_data          = '0;
    dout_valid         = 1'b0;
    dout_startofpacket = 1'b0;
    dout_endofpacket   = 1'b0;
    pass               = 1'b0;
    beat               = 1'b0;
    if (!rst) begin
      // a sop beat is always a header, even mid-packet, so it never reaches dout
      pass = ((state == HDR0) || (state == DATA)) && !din_startofpacket;
      if (pass) begin
        din_ready          = dout_ready;
        dout_data          = din_data;
        dout_valid         = din_valid;
        dout_startofpacket = (state == HDR0);
        dout_endofpacket   = din_endofpacket;
      end else begin
        din_ready = 1'b1;
      end
      beat = din_valid && din_ready;
      if (beat && din_startofpacket) begin
        if (state != IDLE) ctrl_error_n = 1'b1;
        if (din_endofpacket) begin
          state_n = IDLE;
          if (ptype == 4'hF) ctrl_error_n = 1'b1;
        end else begin
          case (ptype)
            4'hF: begin
              state_n  = CTRL;
              cnt_n    = 4'd0;
              shadow_n = 36'd0;
            end
            4'h0:    state_n = HDR0;
            default: state_n = DROP;
          endcase
        end
      end else if (beat) begin
        case (state)
          CTRL: begin
            for (int k = 0; k < 9; k++) begin
              if (cnt == 4'(k / DATA_PLANES))
                shadow_n[35-4*k -: 4] = din_data[(k % DATA_PLANES)*DATA_BITS +: 4];
            end
            cnt_n = cnt_inc;
            if (din_endofpacket) begin
              state_n = IDLE;
              if (cnt_inc == NW) begin
                commit       = 1'b1;
                ctrl_valid_n = 1'b1;
              end else begin
                ctrl_error_n = 1'b1;
              end
            end
          end
          HDR0:    state_n = din_endofpacket ? IDLE : DATA;
          DATA:    if (din_endofpacket) state_n = IDLE;
          DROP:    if (din_endofpacket) state_n = IDLE;
          default: state_n = state;
        endcase
      end
    end
  end

endmodule

// File: doc/my_clipper_decode.md
Name: my_clipper_decode

Overview:
- Avalon-ST video stream decoder and inverse of the control-packet inserter.
- Parses incoming packets by type:
  - Control packets (type 0xF): captured into width/height/interlaced registers, not forwarded.
  - Video data packets (type 0x0): forwarded with the header word stripped; first pixel carries sop.
  - All other packet types: dropped.
- Sits at the input of the clipper datapath and supplies frame geometry to downstream logic.

Parameters:
- DATA_WIDTH, 8, stream data bus width; must be at least DATA_BITS*DATA_PLANES.
- DATA_BITS, 8, bits per symbol (colour plane); must be at least 4.
- DATA_PLANES, 1, symbols per beat; legal values 1, 2, 3.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- din_data  in  DATA_WIDTH  input stream data.
- din_valid  in  1  input beat valid.
- din_startofpacket  in  1  input sop.
- din_endofpacket  in  1  input eop.
- din_ready  out  1  input backpressure.
- dout_data  out  DATA_WIDTH  pixel data out.
- dout_valid  out  1  output beat valid.
- dout_startofpacket  out  1  first pixel of frame.
- dout_endofpacket  out  1  last pixel of frame.
- dout_ready  in  1  downstream ready.
- video_width  out  16  last good control-packet width.
- video_height  out  16  last good control-packet height.
- video_interlaced  out  4  last good interlace nibble.
- ctrl_valid  out  1  one-cycle pulse when new control values are latched.
- ctrl_error  out  1  one-cycle pulse on malformed packet.

Behaviour:
- Beat transfer: a beat transfers when din_valid and din_ready are both high.
- Packet type: on a sop beat, type is din_data[3:0].
- Control nibble order: 9 nibbles, in order width[15:12], width[11:8], width[7:4], width[3:0], height[15:12] … height[3:0], interlaced.
- Nibble placement:
  - Nibble k is in control word floor(k/DATA_PLANES) (words counted after the header).
  - Within that word it sits at bits [s*DATA_BITS+3 : s*DATA_BITS], where s = k mod DATA_PLANES.
  - Upper bits of each symbol are ignored.
- Expected control words after the header, NW: 9 for 1 plane, 5 for 2 planes, 3 for 3 planes.
- State machine: IDLE, CTRL, HDR0, DATA, DROP. Reset state is IDLE.
- IDLE:
  - din_ready=1.
  - A non-sop beat is discarded.
  - A sop beat with type 0xF goes to CTRL and clears the word counter and shadow registers.
  - A sop beat with type 0x0 goes to HDR0.
  - Any other type goes to DROP.
  - A sop beat that also carries eop returns to IDLE; for type 0xF this also pulses ctrl_error.
- CTRL:
  - din_ready=1.
  - Each beat loads its nibbles into shadow registers and increments the word counter.
  - The counter saturates at 15; beats beyond NW are ignored.
  - On the eop beat, go to IDLE:
    - If the total word count equals NW, copy shadow to the video_* outputs on the next edge and pulse ctrl_valid in the same cycle the outputs update.
    - Otherwise pulse ctrl_error and leave the outputs unchanged.
- HDR0 and DATA (pass-through):
  - din_ready = dout_ready.
  - dout_valid = din_valid; dout_data = din_data (combinational).
  - dout_endofpacket = din_endofpacket.
  - dout_startofpacket is high only for the first beat in HDR0.
  - The first transferred beat moves HDR0 to DATA.
  - An eop transfer returns to IDLE.
- DROP: din_ready=1; beats are discarded; eop returns to IDLE.
- Outside HDR0/DATA, dout_valid, dout_startofpacket and dout_endofpacket are all 0.
- Sop beat mid-packet (in CTRL, HDR0, DATA or DROP):
  - The beat is treated as a new header; dout_valid=0 and din_ready=1 for that beat.
  - ctrl_error pulses.
  - Parsing restarts as from IDLE.
  - In DATA, the truncated frame ends without eop; this is accepted.
- Resets and stalls:
  - din_valid low stalls all state; no timeouts.
  - Reset asserted mid-packet returns to IDLE immediately.
  - Reset values: video_width=0, video_height=0, video_interlaced=0, ctrl_valid=0, ctrl_error=0, counters 0.
  - Combinational outputs are 0 while rst is high.
- Latency: data path 0 cycles; control outputs 1 cycle after the eop beat.

Test Plan:
- DATA_PLANES=1, control packet [0xF,0,7,8,0,0,4,3,8,0x3] (eop on last), then video packet [0x0,P0..P3] -> video_width=0x0780, video_height=0x0438, video_interlaced=3, single ctrl_valid pulse; dout emits P0..P3 with sop on P0 and eop on P3.
- DATA_PLANES=3, DATA_BITS=8, control packet words [0x0F, 0x080700, 0x040000, 0x030803] -> width 0x0780, height 0x0438, interlaced 3.
- Short control packet (header plus 6 words, eop) with previous width 0x0780 -> ctrl_error pulse, outputs unchanged, no ctrl_valid.
- Video packet with dout_ready toggling 1/0 each cycle and din_valid gaps -> din_ready mirrors dout_ready; all pixels are delivered in order with no duplicates or losses.
- Packet with type 0x5 spanning 20 beats, then video packet [0x0,A,B] -> nothing from the type-0x5 packet appears on dout; A (sop) and B (eop) are output.
- Sop with type 0x0 arriving while in DATA after 2 pixels -> ctrl_error pulse, the new packet's first pixel carries sop; asserting rst mid-frame -> dout_valid=0 and state returns to IDLE.
